// File: rtl/uart_pkg.sv
// Shared UART definitions: Gray-coded controller states, parity types and legal
// oversampling ratios, common to the RX and TX controllers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b011,
        PARITY = 3'b010,
        STOP   = 3'b110
    } uart_state_t;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    localparam int unsigned PRESCALE_X8  = 8;
    localparam int unsigned PRESCALE_X16 = 16;
    localparam int unsigned PRESCALE_X32 = 32;

    function automatic logic prescale_legal(input int unsigned p);
        return (p == PRESCALE_X8) || (p == PRESCALE_X16) || (p == PRESCALE_X32);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Mid-bit 3-sample capture with 2-of-3 majority vote. The vote is registered two
// ticks after the centre sample and holds until the next bit's vote.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned PRESCALE = 8
) (
    input  logic                        FSM_CLK,
    input  logic                        FSM_RST_ASYN,
    input  logic [$clog2(PRESCALE)-1:0] edge_cnt,
    input  logic                        rx_in,
    output logic                        sampled_bit
);

    localparam int unsigned EW = $clog2(PRESCALE);
    localparam logic [EW-1:0] TICK_A    = EW'(PRESCALE / 2 - 1);
    localparam logic [EW-1:0] TICK_B    = EW'(PRESCALE / 2);
    localparam logic [EW-1:0] TICK_C    = EW'(PRESCALE / 2 + 1);
    localparam logic [EW-1:0] TICK_VOTE = EW'(PRESCALE / 2 + 2);

    logic [2:0] samples;

    always_ff @(posedge FSM_CLK or negedge FSM_RST_ASYN) begin
        if (!FSM_RST_ASYN) begin
            samples     <= '0;
            sampled_bit <= 1'b0;
        end else begin
            if (edge_cnt == TICK_A) samples[0] <= rx_in;
            if (edge_cnt == TICK_B) samples[1] <= rx_in;
            if (edge_cnt == TICK_C) samples[2] <= rx_in;
            if (edge_cnt == TICK_VOTE) begin
                sampled_bit <= (samples[0] & samples[1]) |
                               (samples[0] & samples[2]) |
                               (samples[1] & samples[2]);
            end
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive controller: start detection, LSB-first deserialisation, optional
// parity and stop checking, with one-cycle result pulses.
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int unsigned PRESCALE   = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  FSM_CLK,
    input  logic                  FSM_RST_ASYN,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Parity_Error,
    output logic                  Stop_Error,
    output logic                  RX_Busy
);

    localparam int unsigned EW = $clog2(PRESCALE);
    localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
    localparam logic [EW-1:0] LAST_TICK = EW'(PRESCALE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);

    uart_state_t           state,     state_nxt;
    logic [EW-1:0]         edge_cnt,  edge_nxt;
    logic [BW-1:0]         bit_cnt,   bit_nxt;
    logic [DATA_WIDTH-1:0] shift_reg, shift_nxt;
    logic [DATA_WIDTH-1:0] pdata_nxt;
    logic                  par_bad,   par_bad_nxt;
    logic                  par_en_l,  par_en_nxt;
    logic                  par_typ_l, par_typ_nxt;
    logic                  dv_nxt, pe_nxt, se_nxt;
    logic                  sampled_bit;
    logic                  bit_end;

    uart_rx_sampler #(
        .PRESCALE(PRESCALE)
    ) u_sampler (
        .FSM_CLK     (FSM_CLK),
        .FSM_RST_ASYN(FSM_RST_ASYN),
        .edge_cnt    (edge_cnt),
        .rx_in       (RX_IN),
        .sampled_bit (sampled_bit)
    );

    assign bit_end = (edge_cnt == LAST_TICK);
    assign RX_Busy = (state != IDLE);

    always_ff @(posedge FSM_CLK or negedge FSM_RST_ASYN) begin
        if (!FSM_RST_ASYN) begin
            state        <= IDLE;
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            par_bad      <= 1'b0;
            par_en_l     <= 1'b0;
            par_typ_l    <= 1'b0;
            P_DATA       <= '0;
            Data_Valid   <= 1'b0;
            Parity_Error <= 1'b0;
            Stop_Error   <= 1'b0;
        end else begin
            state        <= state_nxt;
            edge_cnt     <= edge_nxt;
            bit_cnt      <= bit_nxt;
            shift_reg    <= shift_nxt;
            par_bad      <= par_bad_nxt;
            par_en_l     <= par_en_nxt;
            par_typ_l    <= par_typ_nxt;
            P_DATA       <= pdata_nxt;
            Data_Valid   <= dv_nxt;
            Parity_Error <= pe_nxt;
            Stop_Error   <= se_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        edge_nxt    = edge_cnt + 1'b1;
        bit_nxt     = bit_cnt;
        shift_nxt   = shift_reg;
        par_bad_nxt = par_bad;
        par_en_nxt  = par_en_l;
        par_typ_nxt = par_typ_l;
        pdata_nxt   = P_DATA;
        dv_nxt      = 1'b0;
        pe_nxt      = 1'b0;
        se_nxt      = 1'b0;

        case (state)
            IDLE: begin
                edge_nxt = '0;
                bit_nxt  = '0;
                // The detecting cycle counts as tick 0 of the start bit.
                if (!RX_IN) begin
                    state_nxt   = START;
                    edge_nxt    = EW'(1);
                    par_en_nxt  = PAR_EN;
                    par_typ_nxt = PAR_TYP;
                    par_bad_nxt = 1'b0;
                end
            end
            START: begin
                if (bit_end) state_nxt = sampled_bit ? IDLE : DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_nxt = {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
                    if (bit_cnt == LAST_BIT) begin
                        bit_nxt   = '0;
                        state_nxt = par_en_l ? PARITY : STOP;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    par_bad_nxt = sampled_bit ^ (^shift_reg) ^ par_typ_l;
                    state_nxt   = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_nxt = IDLE;
                    if (!sampled_bit) begin
                        se_nxt = 1'b1;
                    end else if (par_bad) begin
                        pe_nxt = 1'b1;
                    end else begin
                        pdata_nxt = shift_reg;
                        dv_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                edge_nxt  = '0;
                bit_nxt   = '0;
            end
        endcase
    end

endmodule
